pito_uart_boot_loader: RTL

//  Serial program loader upstream of the SoC's external memory ports. Consumes received UART bytes,

---
 rtl/pito_uart_boot_loader_pkg.sv | 30 +++
 rtl/pito_boot_word_packer.sv | 57 +++++
 rtl/pito_uart_boot_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pito_uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, frame
// constants and a helper for the 17-bit load-span arithmetic.
package pito_uart_boot_loader_pkg;

   typedef enum logic [3:0] {
      BOOT_IDLE,
      BOOT_TGT,
      BOOT_CNT0,
      BOOT_CNT1,
      BOOT_ADR0,
      BOOT_ADR1,
      BOOT_DATA,
      BOOT_CSUM,
      BOOT_RESP
   } boot_state_e;

   localparam logic [7:0] BOOT_SYNC     = 8'hA5;
   localparam logic [7:0] BOOT_ACK      = 8'h4F;  // 'O'
   localparam logic [7:0] BOOT_NAK      = 8'h45;  // 'E'
   localparam logic [7:0] BOOT_TGT_IMEM = 8'h00;
   localparam logic [7:0] BOOT_TGT_DMEM = 8'h01;

   // One past the last word touched by a load. Computed in 17 bits so that
   // an ADDR/CNT pair wrapping past 16 bits still compares as out of range.
   function automatic logic [16:0] boot_span_end(input logic [15:0] addr,
                                                 input logic [15:0] cnt);
      return {1'b0, addr} + {1'b0, cnt};
   endfunction

endpackage

// File: rtl/pito_boot_word_packer.sv
// Byte-to-word packer for the boot loader.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : restart lane counter and checksum (start of a frame)
//   byte_valid  : byte_in is a payload byte to pack
//   byte_in     : payload byte
//   word        : last completed 32-bit word (byte 0 in [7:0])
//   word_valid  : one-cycle pulse, the cycle after the 4th byte of a word
//   lane_last   : the next accepted byte completes a word
//   csum        : running XOR of all payload bytes since clear
module pito_boot_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid,
   output logic        lane_last,
   output logic [7:0]  csum
);

   logic [1:0]  lane;
   logic [23:0] shreg;

   assign lane_last = (lane == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane       <= 2'd0;
         word_valid <= 1'b0;
         csum       <= 8'h00;
      end else begin
         word_valid <= byte_valid && lane_last;
         if (clear) begin
            lane <= 2'd0;
            csum <= 8'h00;
         end else if (byte_valid) begin
            lane <= lane + 2'd1;
            csum <= csum ^ byte_in;
         end
      end
   end

   // The completed word is latched separately from the shift lanes so that a
   // byte arriving during the write pulse cannot disturb the data being written.
   always_ff @(posedge clk) begin
      if (byte_valid) begin
         case (lane)
            2'd0:    shreg[7:0]   <= byte_in;
            2'd1:    shreg[15:8]  <= byte_in;
            2'd2:    shreg[23:16] <= byte_in;
            default: word         <= {byte_in, shreg};
         endcase
      end
   end

endmodule

// File: rtl/pito_uart_boot_loader.sv
// UART program loader. Parses framed load commands from the UART receiver,
// writes packed words through the imem or dmem external port and answers
// with a single status byte ('O' ok / 'E' error).
//   clk, rst                 : clock, asynchronous active-high reset
//   rx_data, rx_valid        : received byte and its one-cycle strobe
//   tx_data, tx_wr, tx_busy  : status byte, send strobe, transmitter busy
//   pito_program             : core held in program mode during a load
//   imem_req/we/addr/wdata/be: instruction memory write port
//   dmem_req/we/addr/wdata/be: data memory write port
//   busy                     : loader not idle
//   load_err                 : sticky, last frame failed
module pito_uart_boot_loader
   import pito_uart_boot_loader_pkg::*;
#(
   parameter int unsigned IMEM_WORDS     = 4096,
   parameter int unsigned DMEM_WORDS     = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_busy,
   output logic        pito_program,
   output logic        imem_req,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic [3:0]  imem_be,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   output logic        busy,
   output logic        load_err
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [16:0]      IMEM_LIM = 17'(IMEM_WORDS);
   localparam logic [16:0]      DMEM_LIM = 17'(DMEM_WORDS);

   boot_state_e      state, state_n;
   logic             tgt_dmem;
   logic [15:0]      cnt_q;
   logic [7:0]       addr_lo;
   logic [15:0]      cur;
   logic [15:0]      words_acc;
   logic             resp_err, err_n;
   logic [TMO_W-1:0] tmo_cnt;

   logic             sync_acc, data_byte, in_frame, tmo_hit, range_bad, last_word;
   logic [31:0]      pk_word;
   logic             pk_word_valid, pk_lane_last;
   logic [7:0]       pk_csum;

   assign sync_acc  = (state == BOOT_IDLE) && rx_valid && (rx_data == BOOT_SYNC);
   assign data_byte = (state == BOOT_DATA) && rx_valid;
   assign in_frame  = (state != BOOT_IDLE) && (state != BOOT_RESP);
   assign tmo_hit   = (tmo_cnt == TMO_MAX);
   assign range_bad = boot_span_end({rx_data, addr_lo}, cnt_q) > (tgt_dmem ? DMEM_LIM : IMEM_LIM);
   assign last_word = (words_acc == cnt_q - 16'd1);

   pito_boot_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (sync_acc),
      .byte_valid (data_byte),
      .byte_in    (rx_data),
      .word       (pk_word),
      .word_valid (pk_word_valid),
      .lane_last  (pk_lane_last),
      .csum       (pk_csum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      err_n   = resp_err;
      tx_wr   = 1'b0;
      case (state)
         BOOT_IDLE: if (sync_acc) begin
            state_n = BOOT_TGT;
            err_n   = 1'b0;
         end
         BOOT_TGT: if (rx_valid) begin
            if (rx_data > BOOT_TGT_DMEM) begin
               state_n = BOOT_RESP;
               err_n   = 1'b1;
            end else begin
               state_n = BOOT_CNT0;
            end
         end
         BOOT_CNT0: if (rx_valid) state_n = BOOT_CNT1;
         BOOT_CNT1: if (rx_valid) state_n = BOOT_ADR0;
         BOOT_ADR0: if (rx_valid) state_n = BOOT_ADR1;
         BOOT_ADR1: if (rx_valid) begin
            if (range_bad) begin
               state_n = BOOT_RESP;
               err_n   = 1'b1;
            end else if (cnt_q == 16'd0) begin
               state_n = BOOT_CSUM;
            end else begin
               state_n = BOOT_DATA;
            end
         end
         // Leave on the byte that completes the last word; its write pulse
         // then lands while already in CSUM, so the checksum byte may follow
         // back-to-back without being mistaken for payload.
         BOOT_DATA: if (data_byte && pk_lane_last && last_word) state_n = BOOT_CSUM;
         BOOT_CSUM: if (rx_valid) begin
            state_n = BOOT_RESP;
            err_n   = (rx_data != pk_csum);
         end
         BOOT_RESP: if (!tx_busy) begin
            tx_wr   = 1'b1;
            state_n = BOOT_IDLE;
         end
         default: state_n = BOOT_IDLE;
      endcase
      // A byte arriving on the expiry cycle wins over the timeout.
      if (in_frame && !rx_valid && tmo_hit) begin
         state_n = BOOT_RESP;
         err_n   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_dmem  <= 1'b0;
         cnt_q     <= 16'd0;
         addr_lo   <= 8'd0;
         cur       <= 16'd0;
         words_acc <= 16'd0;
         resp_err  <= 1'b0;
         load_err  <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         resp_err <= err_n;
         if (state == BOOT_TGT  && rx_valid) tgt_dmem     <= rx_data[0];
         if (state == BOOT_CNT0 && rx_valid) cnt_q[7:0]   <= rx_data;
         if (state == BOOT_CNT1 && rx_valid) cnt_q[15:8]  <= rx_data;
         if (state == BOOT_ADR0 && rx_valid) addr_lo      <= rx_data;
         if (state == BOOT_ADR1 && rx_valid) begin
            cur       <= {rx_data, addr_lo};
            words_acc <= 16'd0;
         end else if (pk_word_valid) begin
            cur <= cur + 16'd1;
         end
         if (data_byte && pk_lane_last) words_acc <= words_acc + 16'd1;

         if (sync_acc)              load_err <= 1'b0;
         else if (tx_wr && resp_err) load_err <= 1'b1;

         // Inter-byte timer: cleared by any byte, saturating at the limit.
         if (rx_valid || !in_frame) tmo_cnt <= '0;
         else if (!tmo_hit)         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Only the selected port ever sees a pulse; all fields read 0 otherwise.
   assign imem_req   = pk_word_valid & ~tgt_dmem;
   assign imem_we    = imem_req;
   assign imem_addr  = imem_req ? {16'h0000, cur} : 32'h0;
   assign imem_wdata = imem_req ? pk_word : 32'h0;
   assign imem_be    = imem_req ? 4'hF : 4'h0;

   assign dmem_req   = pk_word_valid & tgt_dmem;
   assign dmem_we    = dmem_req;
   assign dmem_addr  = dmem_req ? {16'h0000, cur} : 32'h0;
   assign dmem_wdata = dmem_req ? pk_word : 32'h0;
   assign dmem_be    = dmem_req ? 4'hF : 4'h0;

   assign tx_data      = tx_wr ? (resp_err ? BOOT_NAK : BOOT_ACK) : 8'h00;
   assign busy         = (state != BOOT_IDLE);
   assign pito_program = busy;

endmodule
